// File: rtl/arr_word_serializer_if.sv
//==============================================================================
// arr_word_serializer_if
// Source array plus valid/ready word stream between the bank and its consumer.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface arr_word_serializer_if #(
  parameter int n = 4,
  parameter int m = 15
);
  localparam int IW = (m > 0) ? $clog2(m + 1) : 1;

  logic [n-1:0]  arr_i [0:m];
  logic          start_i;
  logic          ready_i;
  logic          valid_o;
  logic [n-1:0]  data_o;
  logic [IW-1:0] idx_o;
  logic          busy_o;
  logic          done_o;

  modport slave (
    input  arr_i, start_i, ready_i,
    output valid_o, data_o, idx_o, busy_o, done_o
  );

  modport master (
    output arr_i, start_i, ready_i,
    input  valid_o, data_o, idx_o, busy_o, done_o
  );
endinterface

`default_nettype wire

// File: rtl/arr_word_serializer.sv
//==============================================================================
// arr_word_serializer
// Snapshots an (m+1)-word register array on start and streams it index 0 first.
// Revision: 1.0
//==============================================================================
`default_nettype none

module arr_word_serializer #(
  parameter int           n     = 4,
  parameter int           m     = 15,
  parameter logic [n-1:0] value = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  arr_word_serializer_if.slave bus
);
  localparam int            IW       = (m > 0) ? $clog2(m + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(m);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [n-1:0]  snap [0:m];
  logic          capture;
  logic          valid, valid_nx;
  logic          busy, busy_nx;
  logic          done, done_nx;
  logic [n-1:0]  data, data_nx;
  logic [IW-1:0] idx, idx_nx, idx_inc;

  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      data  <= value;
      idx   <= '0;
    end else begin
      state <= state_nx;
      valid <= valid_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      data  <= data_nx;
      idx   <= idx_nx;
    end
  end

  // The snapshot is the burst's private copy; arr_i is only looked at on capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i <= m; i++) snap[i] <= value;
    end else if (capture) begin
      for (int i = 0; i <= m; i++) snap[i] <= bus.arr_i[i];
    end
  end

  always_comb begin
    state_nx = state;
    valid_nx = valid;
    busy_nx  = busy;
    done_nx  = 1'b0;
    data_nx  = data;
    idx_nx   = idx;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        data_nx  = value;
        idx_nx   = '0;
        if (bus.start_i) begin
          capture  = 1'b1;
          state_nx = SEND;
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          data_nx  = bus.arr_i[0];
        end
      end
      SEND: begin
        if (bus.ready_i) begin
          if (idx == LAST_IDX) begin
            state_nx = DONE;
            valid_nx = 1'b0;
            done_nx  = 1'b1;
            data_nx  = value;
            idx_nx   = '0;
          end else begin
            idx_nx  = idx_inc;
            data_nx = snap[idx_inc];
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        data_nx  = value;
        idx_nx   = '0;
      end
    endcase
  end

  assign bus.valid_o = valid;
  assign bus.data_o  = data;
  assign bus.idx_o   = idx;
  assign bus.busy_o  = busy;
  assign bus.done_o  = done;
endmodule

`default_nettype wire

// File: tb/tb_arr_word_serializer.sv
//==============================================================================
// tb_arr_word_serializer
// Scoreboard bench for the array word serializer (m=3 and m=0 instances).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_arr_word_serializer;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   e0;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] idx;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  arr_word_serializer_if #(.n(4), .m(3)) bus_a ();
  arr_word_serializer_if #(.n(4), .m(0)) bus_b ();

  arr_word_serializer #(.n(4), .m(3), .value(4'hA)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  arr_word_serializer #(.n(4), .m(0), .value(4'h0)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_a(input logic [3:0] d, input logic [3:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    q_a.push_back(e);
  endtask

  // Waits (bounded) for done_o and checks how many edges after capture it rose.
  task automatic wait_done(input string name, input bit use_b, input int start, input int exp_edges);
    while (!(use_b ? bus_b.done_o : bus_a.done_o) && (cyc - start) < 40) tick();
    check(name, cyc - start, exp_edges);
  endtask

  // Monitors: a word transfers at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (bus_a.valid_o && bus_a.ready_i) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_word", q_a.size(), 1);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data", bus_a.data_o, e.data);
        check("a_idx", bus_a.idx_o, e.idx);
      end
    end
    if (bus_b.valid_o && bus_b.ready_i) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_word", q_b.size(), 1);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data", bus_b.data_o, e.data);
        check("b_idx", bus_b.idx_o, e.idx);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus_a.arr_i   = '{4'h0, 4'h0, 4'h0, 4'h0};
    bus_a.start_i = 1'b0;
    bus_a.ready_i = 1'b0;
    bus_b.arr_i   = '{4'h0};
    bus_b.start_i = 1'b0;
    bus_b.ready_i = 1'b0;
    #2 rst = 1'b0;

    // Reset values
    tick(); tick();
    @(negedge clk);
    check("rst_valid", bus_a.valid_o, 0);
    check("rst_data", bus_a.data_o, 4'hA);
    check("rst_idx", bus_a.idx_o, 0);
    check("rst_busy", bus_a.busy_o, 0);
    check("rst_done", bus_a.done_o, 0);
    tick();
    rst = 1'b1;
    tick();

    // Back-to-back stream
    bus_a.arr_i   = '{4'h1, 4'h2, 4'h3, 4'h4};
    bus_a.ready_i = 1'b1;
    bus_a.start_i = 1'b1;
    push_a(4'h1, 0); push_a(4'h2, 1); push_a(4'h3, 2); push_a(4'h4, 3);
    tick();
    e0 = cyc;
    bus_a.start_i = 1'b0;
    check("b2b_first_valid", bus_a.valid_o, 1);
    check("b2b_first_busy", bus_a.busy_o, 1);
    wait_done("b2b_done_latency", 1'b0, e0, 4);
    check("b2b_done_busy", bus_a.busy_o, 1);
    check("b2b_done_valid", bus_a.valid_o, 0);
    check("b2b_done_data", bus_a.data_o, 4'hA);
    tick();
    check("b2b_idle_done", bus_a.done_o, 0);
    check("b2b_idle_busy", bus_a.busy_o, 0);
    check("b2b_queue_empty", q_a.size(), 0);

    // Backpressure at idx 1
    bus_a.start_i = 1'b1;
    push_a(4'h1, 0); push_a(4'h2, 1); push_a(4'h3, 2); push_a(4'h4, 3);
    tick();
    e0 = cyc;
    bus_a.start_i = 1'b0;
    tick();
    bus_a.ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", bus_a.valid_o, 1);
      check("stall_data", bus_a.data_o, 4'h2);
      check("stall_idx", bus_a.idx_o, 1);
    end
    bus_a.ready_i = 1'b1;
    wait_done("stall_done_latency", 1'b0, e0, 7);
    tick();
    check("stall_queue_empty", q_a.size(), 0);

    // Snapshot isolation; start ignored during SEND
    bus_a.start_i = 1'b1;
    push_a(4'h1, 0); push_a(4'h2, 1); push_a(4'h3, 2); push_a(4'h4, 3);
    tick();
    e0 = cyc;
    bus_a.arr_i = '{4'hF, 4'hF, 4'hF, 4'hF};
    tick(); tick();
    bus_a.start_i = 1'b0;
    wait_done("iso_done_latency", 1'b0, e0, 4);
    tick(); tick(); tick();
    check("iso_no_second_valid", bus_a.valid_o, 0);
    check("iso_no_second_busy", bus_a.busy_o, 0);
    check("iso_queue_empty", q_a.size(), 0);

    // Reset mid-burst at idx 2
    bus_a.arr_i   = '{4'h1, 4'h2, 4'h3, 4'h4};
    bus_a.start_i = 1'b1;
    push_a(4'h1, 0); push_a(4'h2, 1);
    tick();
    bus_a.start_i = 1'b0;
    tick(); tick();
    check("mid_idx_before_rst", bus_a.idx_o, 2);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", bus_a.valid_o, 0);
    check("mid_rst_data", bus_a.data_o, 4'hA);
    check("mid_rst_idx", bus_a.idx_o, 0);
    check("mid_rst_busy", bus_a.busy_o, 0);
    tick();
    rst = 1'b1;
    bus_a.arr_i   = '{4'h5, 4'h6, 4'h7, 4'h8};
    bus_a.start_i = 1'b1;
    push_a(4'h5, 0); push_a(4'h6, 1); push_a(4'h7, 2); push_a(4'h8, 3);
    tick();
    e0 = cyc;
    bus_a.start_i = 1'b0;
    wait_done("post_rst_done_latency", 1'b0, e0, 4);
    tick();
    check("post_rst_queue_empty", q_a.size(), 0);

    // m=0 single-word burst
    bus_b.arr_i   = '{4'h9};
    bus_b.ready_i = 1'b1;
    bus_b.start_i = 1'b1;
    begin
      exp_t e;
      e.data = 4'h9;
      e.idx  = 4'h0;
      q_b.push_back(e);
    end
    tick();
    e0 = cyc;
    bus_b.start_i = 1'b0;
    check("m0_valid", bus_b.valid_o, 1);
    check("m0_busy", bus_b.busy_o, 1);
    wait_done("m0_done_latency", 1'b1, e0, 1);
    tick();
    check("m0_idle_done", bus_b.done_o, 0);
    check("m0_idle_busy", bus_b.busy_o, 0);
    check("m0_queue_empty", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
